// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
//   state_e        : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digit_t    : one packed BCD digit (one 7-segment decoder input)
//   min_bcd_digits : smallest digit count that can hold 2^width-1
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  // Decimal digits in 2^width-1 is floor(width*log10(2))+1. Because
  // width*log10(2) is never an integer for width > 0, this equals
  // ceil(width*log10(2)). 0.30103 is used as log10(2) in fixed point.
  function automatic int min_bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is >= 5, so
// the following left shift carries correctly into the next decimal digit.
//   digit_in  : scratch digit before the shift
//   digit_out : corrected digit (digit_in + 3 if digit_in >= 5, else digit_in)
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? bcd_digit_t'(digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock,
// MSB first). A conversion takes WIDTH shift cycles plus one cycle to
// reach DONE; done pulses for the single DONE cycle and bcd_out holds the
// result until the next completion.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : request a conversion of bin_in (only looked at in IDLE)
//   bin_in  : unsigned binary value, captured when start is accepted
//   busy    : high in SHIFT and DONE
//   done    : one-cycle completion pulse
//   bcd_out : packed BCD result, digit 0 in [3:0]
module binary_to_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  if (DIGITS < min_bcd_digits(WIDTH)) begin : g_digits_too_few
    $error("binary_to_bcd: DIGITS=%0d cannot hold 2^%0d-1", DIGITS, WIDTH);
  end

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   shift_q,   shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  // One correction cell per scratch digit; all digits are corrected in
  // parallel before the combined shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (scratch_q[4*g +: 4]),
      .digit_out (scratch_adj[4*g +: 4])
    );
  end

  always_comb begin
    // NOTE: every *_d takes its held value first, so no path through the
    // case statement leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d   = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // The counter only decrements while non-zero, so it cannot wrap;
        // reaching zero means all WIDTH bits have been shifted in.
        if (cnt_q != '0) begin
          {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
          cnt_d                = cnt_q - CNT_W'(1);
        end else begin
          // Result is published on entry so it is valid during DONE.
          bcd_d   = scratch_q;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of the others.
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign bcd_out = bcd_q;

endmodule
